// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encoding and default width for the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
// ============================================================================
// Module      : half_adder / full_adder
// Description : One-bit full adder from two half adders and an OR gate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    xor u_xor (s, x, y);
    and u_and (c, x, y);

endmodule

module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (.x(x),    .y(y),    .s(w_s0), .c(w_c0));
    half_adder u_ha1 (.x(w_s0), .y(c_in), .s(s),    .c(w_c1));

    or u_or (c_out, w_c0, w_c1);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial LSB-first adder with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    sa_state_t          r_state;
    sa_state_t          w_next;
    logic [WIDTH-1:0]   r_sh_a;
    logic [WIDTH-1:0]   r_sh_b;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_result_nxt;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_count;
    logic               w_s;
    logic               w_co;

    full_adder u_fa (
        .x    (r_sh_a[0]),
        .y    (r_sh_b[0]),
        .c_in (r_carry),
        .s    (w_s),
        .c_out(w_co)
    );

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands in place.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_result_nxt = w_s;
        end else begin : g_res_wn
            assign w_result_nxt = {w_s, r_result[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_count == c_LAST) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_a   <= '0;
            r_sh_b   <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
        end else if (r_state == IDLE) begin
            if (in_valid) begin
                r_sh_a  <= a;
                r_sh_b  <= b;
                r_carry <= c_in;
                r_count <= '0;
            end
        end else if (r_state == RUN) begin
            r_result <= w_result_nxt;
            r_carry  <= w_co;
            r_sh_a   <= r_sh_a >> 1;
            r_sh_b   <= r_sh_b >> 1;
            r_count  <= r_count + c_CNT_W'(1);
        end
    end

    assign sum   = r_result;
    assign c_out = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module      : tb_serial_adder
// Description : Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #50 clk = ~clk;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, c_in8, c_out8, busy8;
    logic [7:0] a8, b8, sum8;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, c_in1, c_out1, busy1;
    logic [0:0] a1, b1, sum1;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .c_in(c_in8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .c_out(c_out8), .busy(busy8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .c_in(c_in1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .c_out(c_out1), .busy(busy1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [8:0] sb8[$];
    logic [1:0] sb1[$];
    int         acc8[$];
    int         acc1[$];
    logic [8:0] e8;
    logic [1:0] e1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            sb8.delete();
            acc8.delete();
        end else begin
            if (in_valid8 && in_ready8) begin
                sb8.push_back({1'b0, a8} + {1'b0, b8} + 9'(c_in8));
                acc8.push_back(cyc);
            end
            if (out_valid8 && out_ready8) begin
                if (sb8.size() == 0) begin
                    check("w8_unexpected_out", 1, 0);
                end else begin
                    e8 = sb8.pop_front();
                    check("w8_sum", 32'(sum8), 32'(e8[7:0]));
                    check("w8_cout", 32'(c_out8), 32'(e8[8]));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            sb1.delete();
            acc1.delete();
        end else begin
            if (in_valid1 && in_ready1) begin
                sb1.push_back({1'b0, a1} + {1'b0, b1} + 2'(c_in1));
                acc1.push_back(cyc);
            end
            if (out_valid1 && out_ready1) begin
                if (sb1.size() == 0) begin
                    check("w1_unexpected_out", 1, 0);
                end else begin
                    e1 = sb1.pop_front();
                    check("w1_sum", 32'(sum1), 32'(e1[0]));
                    check("w1_cout", 32'(c_out1), 32'(e1[1]));
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        a8 = va; b8 = vb; c_in8 = vc; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
    endtask

    // Advances until out_valid rises (bounded) and checks how many edges it took.
    task automatic wait_out8(input int lat, input string tag);
        int n = 0;
        while (!out_valid8 && n < 40) begin
            tick();
            n++;
        end
        check(tag, n, lat);
    endtask

    task automatic wait_out1(input int lat, input string tag);
        int n = 0;
        while (!out_valid1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, n, lat);
    endtask

    task automatic to_idle8;
        tick();
        check("w8_idle_ready", 32'(in_ready8), 1);
        check("w8_idle_valid", 32'(out_valid8), 0);
    endtask

    task automatic run_op8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        start8(va, vb, vc);
        check("w8_busy", 32'(busy8), 1);
        check("w8_run_ready", 32'(in_ready8), 0);
        wait_out8(8, "w8_latency");
        to_idle8();
    endtask

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; c_in8 = 0;
        in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; c_in1 = 0;
        rst_n = 0;
        repeat (2) tick();
        check("rst_in_ready", 32'(in_ready8), 1);
        check("rst_out_valid", 32'(out_valid8), 0);
        check("rst_busy", 32'(busy8), 0);
        check("rst_sum", 32'(sum8), 0);
        check("rst_cout", 32'(c_out8), 0);
        check("rst_w1_in_ready", 32'(in_ready1), 1);
        rst_n = 1;
        tick();

        out_ready8 = 1;
        run_op8(8'h5A, 8'h3C, 1'b0);
        run_op8(8'hFF, 8'h01, 1'b0);
        run_op8(8'hFF, 8'hFF, 1'b1);

        // Backpressure: result must hold while the consumer stalls.
        out_ready8 = 0;
        start8(8'h5A, 8'h3C, 1'b0);
        wait_out8(8, "w8_bp_latency");
        repeat (5) begin
            tick();
            check("w8_bp_valid", 32'(out_valid8), 1);
            check("w8_bp_sum", 32'(sum8), 32'h96);
            check("w8_bp_cout", 32'(c_out8), 0);
            check("w8_bp_in_ready", 32'(in_ready8), 0);
        end
        out_ready8 = 1;
        to_idle8();

        // New operands offered mid-RUN must be ignored.
        start8(8'h5A, 8'h3C, 1'b0);
        repeat (3) tick();
        a8 = 8'h11; b8 = 8'h22; c_in8 = 1'b1; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        check("w8_ign_busy", 32'(busy8), 1);
        wait_out8(4, "w8_ign_latency");
        to_idle8();

        // Reset mid-RUN abandons the operation.
        start8(8'h5A, 8'h3C, 1'b0);
        repeat (3) tick();
        rst_n = 0;
        #1;
        check("w8_mrst_in_ready", 32'(in_ready8), 1);
        check("w8_mrst_valid", 32'(out_valid8), 0);
        check("w8_mrst_sum", 32'(sum8), 0);
        check("w8_mrst_cout", 32'(c_out8), 0);
        check("w8_mrst_busy", 32'(busy8), 0);
        tick();
        rst_n = 1;
        tick();
        run_op8(8'h12, 8'h34, 1'b0);

        // Back-to-back with in_valid held high.
        a8 = 8'h01; b8 = 8'h01; c_in8 = 1'b0; in_valid8 = 1'b1;
        tick();
        a8 = 8'h80; b8 = 8'h80;
        wait_out8(8, "w8_b2b_lat1");
        tick();
        tick();
        in_valid8 = 1'b0;
        wait_out8(8, "w8_b2b_lat2");
        to_idle8();
        if (acc8.size() >= 2) check("w8_period", acc8[acc8.size()-1] - acc8[acc8.size()-2], 10);
        else                  check("w8_period", 0, 10);

        // WIDTH=1 back-to-back.
        out_ready1 = 1;
        a1 = 1'b1; b1 = 1'b1; c_in1 = 1'b1; in_valid1 = 1'b1;
        tick();
        check("w1_busy", 32'(busy1), 1);
        a1 = 1'b0; b1 = 1'b1; c_in1 = 1'b0;
        wait_out1(1, "w1_lat1");
        tick();
        tick();
        in_valid1 = 1'b0;
        wait_out1(1, "w1_lat2");
        tick();
        check("w1_idle_ready", 32'(in_ready1), 1);
        if (acc1.size() >= 2) check("w1_period", acc1[acc1.size()-1] - acc1[acc1.size()-2], 3);
        else                  check("w1_period", 0, 3);

        tick();
        check("w8_sb_empty", sb8.size(), 0);
        check("w1_sb_empty", sb1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
